// File: rtl/neander_pkg.sv
// Shared encodings for the Neander control unit: opcodes, ALU selects and sequencer states.
package neander_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_AND    = 3'b001;
  localparam logic [2:0] ALU_OR     = 3'b010;
  localparam logic [2:0] ALU_NOT    = 3'b011;
  localparam logic [2:0] ALU_PASS_Y = 3'b100;

  typedef enum logic [3:0] {
    T0   = 4'd0,
    T1   = 4'd1,
    T2   = 4'd2,
    T3   = 4'd3,
    T4   = 4'd4,
    T5   = 4'd5,
    T6   = 4'd6,
    T7   = 4'd7,
    HALT = 4'd8
  } state_t;

  function automatic logic is_jump(input logic [3:0] opc);
    return (opc == OP_JMP) || (opc == OP_JN) || (opc == OP_JZ);
  endfunction

endpackage

// File: rtl/neander_ctrl.sv
// Neander control unit: T0..T7 sequencer plus HALT, with strobes decoded from state, opcode and flags.
module neander_ctrl
  import neander_pkg::*;
(
  input  logic       ck,
  input  logic       ereset,
  input  logic       run,
  input  logic [3:0] op,
  input  logic       n,
  input  logic       z,
  output logic       sel_rdm,
  output logic       load_rem,
  output logic       load_rdm,
  output logic       load_ri,
  output logic       load_ac,
  output logic       load_nz,
  output logic       load_pc,
  output logic       inc_pc,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [2:0] alu_sel,
  output logic       halted,
  output logic [2:0] tstate
);

  state_t state, next_state;

  always_ff @(posedge ck) begin
    if (ereset) state <= T0;
    else        state <= next_state;
  end

  // Taken jumps reach T4/T5, so the opcode alone identifies them there without storing the flag.
  always_comb begin
    next_state = T0;
    sel_rdm  = 1'b0;
    load_rem = 1'b0;
    load_rdm = 1'b0;
    load_ri  = 1'b0;
    load_ac  = 1'b0;
    load_nz  = 1'b0;
    load_pc  = 1'b0;
    inc_pc   = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    alu_sel  = ALU_PASS_Y;
    halted   = 1'b0;
    tstate   = (state == HALT) ? 3'd0 : state[2:0];

    case (state)
      T0: begin
        if (run) begin
          load_rem   = 1'b1;
          next_state = T1;
        end else begin
          next_state = T0;
        end
      end
      T1: begin
        mem_rd     = 1'b1;
        inc_pc     = 1'b1;
        next_state = T2;
      end
      T2: begin
        load_ri    = 1'b1;
        next_state = T3;
      end
      T3: begin
        case (op)
          OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_JMP: begin
            load_rem   = 1'b1;
            next_state = T4;
          end
          OP_NOT: begin
            alu_sel    = ALU_NOT;
            load_ac    = 1'b1;
            load_nz    = 1'b1;
            next_state = T0;
          end
          OP_JN, OP_JZ: begin
            if ((op == OP_JN && n) || (op == OP_JZ && z)) begin
              load_rem   = 1'b1;
              next_state = T4;
            end else begin
              inc_pc     = 1'b1;
              next_state = T0;
            end
          end
          OP_HLT:  next_state = HALT;
          default: next_state = T0;
        endcase
      end
      T4: begin
        mem_rd     = 1'b1;
        inc_pc     = !is_jump(op);
        next_state = T5;
      end
      T5: begin
        if (is_jump(op)) begin
          load_pc    = 1'b1;
          next_state = T0;
        end else begin
          load_rem   = 1'b1;
          sel_rdm    = 1'b1;
          next_state = T6;
        end
      end
      T6: begin
        if (op == OP_STA) load_rdm = 1'b1;
        else              mem_rd   = 1'b1;
        next_state = T7;
      end
      T7: begin
        if (op == OP_STA) begin
          mem_wr = 1'b1;
        end else begin
          case (op)
            OP_ADD:  alu_sel = ALU_ADD;
            OP_OR:   alu_sel = ALU_OR;
            OP_AND:  alu_sel = ALU_AND;
            default: alu_sel = ALU_PASS_Y;
          endcase
          load_ac = 1'b1;
          load_nz = 1'b1;
        end
        next_state = T0;
      end
      HALT: begin
        halted     = 1'b1;
        next_state = HALT;
      end
      default: next_state = T0;
    endcase

    // Reset masks every output so nothing fires on the cycle the sequencer is being cleared.
    if (ereset) begin
      sel_rdm  = 1'b0;
      load_rem = 1'b0;
      load_rdm = 1'b0;
      load_ri  = 1'b0;
      load_ac  = 1'b0;
      load_nz  = 1'b0;
      load_pc  = 1'b0;
      inc_pc   = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      alu_sel  = ALU_PASS_Y;
      halted   = 1'b0;
      tstate   = 3'd0;
    end
  end

endmodule
